// File: rtl/ps2_byte_receiver.sv
// ----------------------------------------------------------------------------
// ps2_byte_receiver
//
// Turns the raw device-to-host PS/2 line (ps2_clk / ps2_dat) into validated
// scan-code bytes for the downstream keyboard decoder.
//
// A frame is 11 bits: start(0), 8 data bits LSB-first, odd parity, stop(1).
// Every bit is sampled on a falling edge of ps2_clk. An accepted byte moves
// the previous byte to ps2_out, so a break sequence (F0 xx) appears as
// ps2_out == 8'hF0 together with ps2_key_data == xx.
//
// Optional build macro:
//   PS2_RX_PARITY_CHECK_EN  defined   -> odd parity enforced; a mismatch
//                                        discards the byte and pulses
//                                        frame_error.
//                           undefined -> the parity bit is sampled but ignored.
//
// Parameters:
//   TIMEOUT_CYCLES  system clocks allowed between ps2_clk falls inside a
//                   frame before the frame is abandoned (2..65535).
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-low reset
//   ps2_clk          raw PS/2 clock pin (asynchronous, idle high)
//   ps2_dat          raw PS/2 data pin  (asynchronous, idle high)
//   ps2_key_data     last accepted byte, held until the next one
//   ps2_key_pressed  one-cycle strobe: ps2_key_data just updated
//   ps2_out          byte accepted before the current ps2_key_data
//   frame_error      one-cycle strobe: frame discarded
// ----------------------------------------------------------------------------
module ps2_byte_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       frame_error
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers; bit 0 = ps2_clk, bit 1 = ps2_dat. Both reset to
  // the idle-high level so a reset never fabricates a falling edge.
  // --------------------------------------------------------------------------
  logic [1:0] line_raw;
  logic [1:0] line_sync;

  assign line_raw = {ps2_dat, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= line_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign line_sync[gi] = sync_reg;
    end
  endgenerate

  logic clk_sync;
  logic dat_sync;
  logic clk_prev_reg;
  logic fall;

  assign clk_sync = line_sync[0];
  assign dat_sync = line_sync[1];
  assign fall     = clk_prev_reg & ~clk_sync;

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  state_t      state_reg,    state_next;
  logic [2:0]  bit_cnt_reg,  bit_cnt_next;
  logic [7:0]  shift_reg,    shift_next;
  logic        parity_reg,   parity_next;
  logic [15:0] tmo_cnt_reg,  tmo_cnt_next;
  logic [7:0]  key_data_reg, key_data_next;
  logic [7:0]  out_reg,      out_next;
  logic        pressed_reg,  pressed_next;
  logic        error_reg,    error_next;
  logic        parity_ok;

`ifdef PS2_RX_PARITY_CHECK_EN
  // Odd parity: data plus parity bit must carry an odd number of ones.
  assign parity_ok = ^{shift_reg, parity_reg};
`else
  logic unused_parity;
  assign parity_ok     = 1'b1;
  assign unused_parity = parity_reg;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_prev_reg <= 1'b1;
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      parity_reg   <= 1'b0;
      tmo_cnt_reg  <= 16'd0;
      key_data_reg <= 8'h00;
      out_reg      <= 8'h00;
      pressed_reg  <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      clk_prev_reg <= clk_sync;
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      key_data_reg <= key_data_next;
      out_reg      <= out_next;
      pressed_reg  <= pressed_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    key_data_next = key_data_reg;
    out_next      = out_reg;
    pressed_next  = 1'b0;
    error_next    = 1'b0;
    // The watchdog only runs while a frame is in progress.
    tmo_cnt_next  = (state_reg == IDLE || fall) ? 16'd0 : tmo_cnt_reg + 16'd1;

    case (state_reg)
      IDLE: begin
        // A fall with data high is line noise, not a start bit.
        if (fall && !dat_sync) begin
          state_next   = DATA;
          bit_cnt_next = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_next   = {dat_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_next = dat_sync;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (dat_sync && parity_ok) begin
            out_next      = key_data_reg;
            key_data_next = shift_reg;
            pressed_next  = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A fall in the same cycle counts as progress, so it wins over the timeout.
    if (state_reg != IDLE && !fall && tmo_cnt_reg == TIMEOUT_LAST) begin
      state_next   = IDLE;
      error_next   = 1'b1;
      tmo_cnt_next = 16'd0;
    end
  end

  assign ps2_key_data    = key_data_reg;
  assign ps2_key_pressed = pressed_reg;
  assign ps2_out         = out_reg;
  assign frame_error     = error_reg;

endmodule
